// File: rtl/led_frame_shifter.sv
// led_frame_shifter
//   Serial output stage for the daisy-chained LED driver boards. One frame of
//   c_boards*32 channel words is taken from an upstream source over a
//   valid/ready handshake and shifted out MSB-first on o_clk/o_dai. After the
//   last bit, o_lat is pulsed so that a frame only becomes visible once it has
//   been shifted completely.
//
// Parameters
//   c_boards      number of 32-channel driver boards in the chain
//   c_bps         bits per channel word
//   c_clk_div     serial clock half-period in i_clk cycles (>= 1)
//   c_lat_cycles  o_lat high time in i_clk cycles (>= 1)
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  single-cycle frame start request (honoured only when idle)
//   i_data   channel word, first accepted word is shifted first
//   i_valid  i_data is valid
//   o_ready  block accepts i_data this cycle
//   o_busy   frame in progress
//   o_done   one-cycle pulse after the frame has been latched
//   o_clk    serial clock to the drivers (registered)
//   o_dai    serial data to the drivers
//   o_lat    latch pulse to the drivers
module led_frame_shifter #(
  parameter int c_boards     = 1,
  parameter int c_bps        = 12,
  parameter int c_clk_div    = 1,
  parameter int c_lat_cycles = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [c_bps-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_clk,
  output logic             o_dai,
  output logic             o_lat
);

  localparam int c_chans = c_boards * 32;
  localparam int ch_w    = (c_chans > 1) ? $clog2(c_chans) : 1;
  localparam int bit_w   = (c_bps > 1) ? $clog2(c_bps) : 1;
  localparam int div_w   = $clog2(c_clk_div + 1);
  localparam int lat_w   = (c_lat_cycles > 1) ? $clog2(c_lat_cycles + 1) : 1;

  localparam logic [ch_w-1:0]  ch_last  = ch_w'(c_chans - 1);
  localparam logic [bit_w-1:0] bit_top  = bit_w'(c_bps - 1);
  localparam logic [div_w-1:0] div_last = div_w'(c_clk_div - 1);
  localparam logic [lat_w-1:0] lat_last = lat_w'(c_lat_cycles - 1);

  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_shift_lo,
    st_shift_hi,
    st_latch,
    st_done
  } state_t;

  state_t             state, state_nx;
  logic [c_bps-1:0]   sreg, sreg_nx, sreg_shl;
  logic [bit_w-1:0]   bit_cnt, bit_nx;
  logic [ch_w-1:0]    ch_cnt, ch_nx;
  logic [div_w-1:0]   div_cnt, div_nx;
  logic [lat_w-1:0]   lat_cnt, lat_cnt_nx;
  logic               div_end;
  logic               dai_nx, ready_nx, busy_nx, clk_nx, lat_nx, done_nx;

  // All outputs are registered; their next values are decoded from the next
  // state so that each output changes on the same edge as the state it
  // belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= st_idle;
      sreg    <= '0;
      bit_cnt <= '0;
      ch_cnt  <= '0;
      div_cnt <= '0;
      lat_cnt <= '0;
      o_dai   <= 1'b0;
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      o_clk   <= 1'b0;
      o_lat   <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      bit_cnt <= bit_nx;
      ch_cnt  <= ch_nx;
      div_cnt <= div_nx;
      lat_cnt <= lat_cnt_nx;
      o_dai   <= dai_nx;
      o_ready <= ready_nx;
      o_busy  <= busy_nx;
      o_clk   <= clk_nx;
      o_lat   <= lat_nx;
      o_done  <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_nx     = bit_cnt;
    ch_nx      = ch_cnt;
    div_nx     = div_cnt;
    lat_cnt_nx = lat_cnt;
    dai_nx     = o_dai;
    sreg_shl   = sreg << 1;
    div_end    = (div_cnt == div_last);

    case (state)
      st_idle: begin
        if (i_start) begin
          state_nx = st_load;
        end
      end

      // Underflow stall: with no valid word the low phase simply stretches.
      st_load: begin
        if (i_valid) begin
          sreg_nx  = i_data;
          dai_nx   = i_data[c_bps-1];
          bit_nx   = bit_top;
          div_nx   = '0;
          state_nx = st_shift_lo;
        end
      end

      st_shift_lo: begin
        if (div_end) begin
          div_nx   = '0;
          state_nx = st_shift_hi;
        end else begin
          div_nx = div_cnt + div_w'(1);
        end
      end

      // The next bit is presented on the same edge that drops o_clk, so the
      // data is stable for the full low phase before the next rising edge.
      st_shift_hi: begin
        if (div_end) begin
          div_nx = '0;
          if (bit_cnt != '0) begin
            bit_nx   = bit_cnt - bit_w'(1);
            sreg_nx  = sreg_shl;
            dai_nx   = sreg_shl[c_bps-1];
            state_nx = st_shift_lo;
          end else if (ch_cnt != ch_last) begin
            ch_nx    = ch_cnt + ch_w'(1);
            state_nx = st_load;
          end else begin
            ch_nx      = '0;
            lat_cnt_nx = '0;
            state_nx   = st_latch;
          end
        end else begin
          div_nx = div_cnt + div_w'(1);
        end
      end

      st_latch: begin
        if (lat_cnt == lat_last) begin
          lat_cnt_nx = '0;
          state_nx   = st_done;
        end else begin
          lat_cnt_nx = lat_cnt + lat_w'(1);
        end
      end

      st_done: begin
        state_nx = st_idle;
      end

      default: begin
        state_nx = st_idle;
      end
    endcase

    ready_nx = (state_nx == st_load);
    busy_nx  = (state_nx == st_load) || (state_nx == st_shift_lo) ||
               (state_nx == st_shift_hi) || (state_nx == st_latch);
    clk_nx   = (state_nx == st_shift_hi);
    lat_nx   = (state_nx == st_latch);
    done_nx  = (state_nx == st_done);
  end

endmodule

// File: tb/tb_led_frame_shifter.sv
// tb_led_frame_shifter
//   Bench for led_frame_shifter. dut_a uses the default parameters, dut_b a
//   two-board chain with a divided serial clock and a longer latch. A driver
//   model shifts o_dai in on o_clk rising edges and compares the received
//   words against the scoreboard when o_lat rises.
module tb_led_frame_shifter;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        i_valid = 1'b0;
  logic [11:0] i_data  = '0;
  logic        sel     = 1'b0;

  logic a_ready, a_busy, a_done, a_clk, a_dai, a_lat;
  logic b_ready, b_busy, b_done, b_clk, b_dai, b_lat;
  logic m_ready, m_busy, m_done, m_clk, m_dai, m_lat;

  assign m_ready = sel ? b_ready : a_ready;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_clk   = sel ? b_clk   : a_clk;
  assign m_dai   = sel ? b_dai   : a_dai;
  assign m_lat   = sel ? b_lat   : a_lat;

  led_frame_shifter dut_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (start_a),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (a_ready),
    .o_busy  (a_busy),
    .o_done  (a_done),
    .o_clk   (a_clk),
    .o_dai   (a_dai),
    .o_lat   (a_lat)
  );

  led_frame_shifter #(
    .c_boards     (2),
    .c_bps        (12),
    .c_clk_div    (3),
    .c_lat_cycles (4)
  ) dut_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (start_b),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (b_ready),
    .o_busy  (b_busy),
    .o_done  (b_done),
    .o_clk   (b_clk),
    .o_dai   (b_dai),
    .o_lat   (b_lat)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int t0 = 0;
  int cur_d = 1;
  int n_checks = 0;
  int n_pass = 0;

  logic [11:0] exp_q[$];
  logic [11:0] rx[$];

  int   edges, lat_first, lat_len, done_rel, done_cnt;
  int   hi_bad, lo_min, dai_bad, nb, hi_run, lo_run;
  bit   seen_fall;
  logic [11:0] sh = '0;
  logic pclk = 1'b0, plat = 1'b0, pdai = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc - t0);
  endtask

  task automatic clear_mon();
    edges = 0; lat_first = -1; lat_len = 0; done_rel = -1; done_cnt = 0;
    hi_bad = 0; lo_min = 1 << 30; dai_bad = 0; nb = 0; hi_run = 0; lo_run = 0;
    seen_fall = 0;
    rx.delete();
    exp_q.delete();
  endtask

  task automatic poke(input bit use_b, input bit v);
    if (use_b) start_b = v;
    else start_a = v;
  endtask

  // Driver-board model and output monitor, sampled away from the active edge.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      nb = 0;
      rx.delete();
      pclk = 1'b0; plat = 1'b0; pdai = 1'b0;
    end else begin
      if (m_clk && (m_dai !== pdai)) dai_bad++;
      if (m_clk && !pclk) begin
        edges++;
        sh = {sh[10:0], m_dai};
        nb++;
        if (nb == 12) begin
          rx.push_back(sh);
          nb = 0;
        end
        if (seen_fall && lo_run < lo_min) lo_min = lo_run;
        hi_run = 1;
      end else if (!m_clk && pclk) begin
        if (hi_run != cur_d) hi_bad++;
        lo_run = 1;
        seen_fall = 1;
      end else if (m_clk) begin
        hi_run++;
      end else begin
        lo_run++;
      end
      if (m_lat) begin
        lat_len++;
        if (!plat) begin
          lat_first = cyc - t0;
          check("nwords", rx.size(), exp_q.size());
          while (rx.size() > 0 && exp_q.size() > 0)
            check("word", rx.pop_front(), exp_q.pop_front());
        end
      end
      if (m_done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
      pclk = m_clk; plat = m_lat; pdai = m_dai;
    end
  end

  // Runs one frame starting at the current negedge (cycle 0 = start pulse).
  task automatic run_frame(input bit use_b, input int nw, input int d, input int lat,
                           input bit pat, input int stall_idx, input int stall_len,
                           input bit pokes);
    int idx = 0;
    int left = stall_len;
    int rel = 0;
    int done_exp;
    bit acc;
    done_exp = nw * (24 * d + 1) + lat + 1 + stall_len;
    clear_mon();
    sel = use_b;
    cur_d = d;
    t0 = cyc;
    poke(use_b, 1'b1);
    i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    poke(use_b, 1'b0);
    check("ready_c1", m_ready, 1);
    check("busy_c1", m_busy, 1);
    for (int g = 0; g < 20000 && idx < nw; g++) begin
      rel = cyc - t0;
      poke(use_b, pokes && (rel == 100 || rel == done_exp));
      if (idx == stall_idx && left > 0 && (left < stall_len || m_ready)) begin
        i_valid = 1'b0;
        left--;
        check("stall_clk", m_clk, 0);
        check("stall_ready", m_ready, 1);
      end else begin
        i_valid = 1'b1;
        i_data = pat ? 12'hA5C : 12'(idx);
      end
      acc = i_valid && m_ready;
      if (acc) exp_q.push_back(i_data);
      @(posedge i_clk);
      if (acc) idx++;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    check("accepted", idx, nw);
    for (int g = 0; g < 20000; g++) begin
      rel = cyc - t0;
      if (rel >= done_exp + 1) break;
      poke(use_b, pokes && (rel == 100 || rel == done_exp));
      @(negedge i_clk);
    end
    poke(use_b, 1'b0);
    if (pokes) begin
      check("idle_busy", m_busy, 0);
      check("idle_ready", m_ready, 0);
    end
    check("edges", edges, nw * 12);
    check("lat_first", lat_first, done_exp - lat);
    check("lat_len", lat_len, lat);
    check("done_cyc", done_rel, done_exp);
    check("done_cnt", done_cnt, 1);
    check("hi_phase", hi_bad, 0);
    check("lo_min", lo_min, d);
    check("dai_stable", dai_bad, 0);
    check("sb_left", exp_q.size(), 0);
  endtask

  task automatic abort_frame();
    clear_mon();
    sel = 1'b0;
    cur_d = 1;
    t0 = cyc;
    start_a = 1'b1;
    i_valid = 1'b1;
    i_data = 12'hFFF;
    @(posedge i_clk);
    @(negedge i_clk);
    start_a = 1'b0;
    while (cyc - t0 < 300) @(negedge i_clk);
    check("pre_rst_dai", m_dai, 1);
    i_rst_n = 1'b0;
    #1;
    check("rst_clk", m_clk, 0);
    check("rst_dai", m_dai, 0);
    check("rst_lat", m_lat, 0);
    check("rst_busy", m_busy, 0);
    check("rst_ready", m_ready, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    repeat (60) @(negedge i_clk);
    check("abort_lat", lat_len, 0);
    check("abort_done", done_cnt, 0);
    check("abort_busy", m_busy, 0);
    exp_q.delete();
  endtask

  initial begin
    clear_mon();
    repeat (3) @(negedge i_clk);
    check("reset_clk", a_clk, 0);
    check("reset_dai", a_dai, 0);
    check("reset_lat", a_lat, 0);
    check("reset_ready", a_ready, 0);
    check("reset_busy", a_busy, 0);
    check("reset_done", a_done, 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    run_frame(1'b0, 32, 1, 2, 1'b0, -1, 0, 1'b1);
    run_frame(1'b0, 32, 1, 2, 1'b0, 5, 7, 1'b0);
    abort_frame();
    run_frame(1'b0, 32, 1, 2, 1'b0, -1, 0, 1'b0);
    run_frame(1'b1, 64, 3, 4, 1'b1, -1, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
